// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
// Package  : accel_pkg
// Brief    : Shared FSM encoding and geometry helpers for the result gatherer.
// Revision : 1.0
// ============================================================================
package accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    localparam int c_ADDR_MIN_IW = 13;

    function automatic int lanes_per_word(input int bram_w, input int w);
        return bram_w / w;
    endfunction

    function automatic int beats_per_row(input int n, input int w, input int bram_w);
        return (n * w) / bram_w;
    endfunction

    function automatic int col_blocks(input int size_x, input int n);
        return size_x / n;
    endfunction

    function automatic int row_stride(input int size_x, input int w, input int bram_w);
        return (size_x * w) / bram_w;
    endfunction

    // One guard bit above the BRAM address so the sum can never wrap internally.
    function automatic int addr_iw(input int aw);
        return (aw + 1 > c_ADDR_MIN_IW) ? aw + 1 : c_ADDR_MIN_IW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gather_c.sv
`default_nettype none
// ============================================================================
// Module   : gather_c
// Brief    : Captures result rows from the systolic array and scatters them
//            into BRAM, one column block at a time.
// Revision : 1.0
// ============================================================================
module gather_c
    import accel_pkg::*;
#(
    parameter int W             = 8,
    parameter int N             = 64,
    parameter int BRAM_W        = 128,
    parameter int BRAM_AW       = 9,
    parameter int DATA_C_SIZE_X = 64,
    parameter int DATA_C_SIZE_Y = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N-1:0][W-1:0]       c_in,
    input  logic                      c_valid,
    output logic                      c_ready,
    output logic                      bram_clk_c,
    output logic                      bram_en_c,
    output logic                      bram_we_c,
    output logic [BRAM_AW-1:0]        bram_addr_c,
    output logic [BRAM_W-1:0]         bram_wrdata_c,
    input  logic [BRAM_W-1:0]         bram_rddata_c,
    output logic                      blk_done,
    output logic                      all_done,
    output logic                      busy,
    output logic [2:0]                debug_state
);

    localparam int c_L        = lanes_per_word(BRAM_W, W);
    localparam int c_BEATS    = beats_per_row(N, W, BRAM_W);
    localparam int c_ROWS     = DATA_C_SIZE_Y;
    localparam int c_COL_BLKS = col_blocks(DATA_C_SIZE_X, N);
    localparam int c_STRIDE   = row_stride(DATA_C_SIZE_X, W, BRAM_W);
    localparam int c_IW       = addr_iw(BRAM_AW);
    localparam int c_ROW_W    = (c_ROWS > 1) ? $clog2(c_ROWS) : 1;
    localparam int c_BLK_W    = (c_COL_BLKS > 1) ? $clog2(c_COL_BLKS) : 1;
    localparam int c_BEAT_W   = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

    generate
        if ((N * W) % BRAM_W != 0) begin : g_chk_row_width
            $error("gather_c: N*W must be a multiple of BRAM_W");
        end
        if (DATA_C_SIZE_X % N != 0) begin : g_chk_col_blocks
            $error("gather_c: DATA_C_SIZE_X must be a multiple of N");
        end
        if (c_STRIDE * c_ROWS > (1 << BRAM_AW)) begin : g_chk_addr_space
            $error("gather_c: matrix does not fit the BRAM address space");
        end
    endgenerate

    state_t                 r_state;
    logic [c_ROW_W-1:0]     r_row_cnt;
    logic [c_BLK_W-1:0]     r_col_blk;
    logic [c_BEAT_W-1:0]    r_beat;
    logic [N-1:0][W-1:0]    r_buf;
    logic                   r_blk_done;
    logic                   r_all_done;

    logic                   w_wr;
    logic                   w_last_beat;
    logic [N*W-1:0]         w_buf_flat;
    logic                   w_unused;

    assign w_wr        = (r_state == ST_WRITE);
    assign w_last_beat = (r_beat == c_BEAT_W'(c_BEATS - 1));
    assign w_buf_flat  = r_buf;
    assign w_unused    = ^bram_rddata_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_row_cnt  <= '0;
            r_col_blk  <= '0;
            r_beat     <= '0;
            r_buf      <= '0;
            r_blk_done <= 1'b0;
            r_all_done <= 1'b0;
        end else begin
            r_blk_done <= 1'b0;
            r_all_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_CAPTURE;
                        r_row_cnt <= '0;
                        r_col_blk <= '0;
                        r_beat    <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (c_valid) begin
                        r_buf   <= c_in;
                        r_beat  <= '0;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_last_beat) begin
                        r_beat <= '0;
                        if (r_row_cnt != c_ROW_W'(c_ROWS - 1)) begin
                            r_row_cnt <= r_row_cnt + c_ROW_W'(1);
                            r_state   <= ST_CAPTURE;
                        end else begin
                            r_row_cnt  <= '0;
                            r_blk_done <= 1'b1;
                            if (r_col_blk != c_BLK_W'(c_COL_BLKS - 1)) begin
                                r_col_blk <= r_col_blk + c_BLK_W'(1);
                                r_state   <= ST_WAIT;
                            end else begin
                                r_all_done <= 1'b1;
                                r_state    <= ST_IDLE;
                            end
                        end
                    end else begin
                        r_beat <= r_beat + c_BEAT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (start) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The BRAM port is a pure decode of the registered state, so a beat is
    // on the port in the same cycle its counter value is held.
    assign bram_clk_c    = clk;
    assign bram_en_c     = w_wr;
    assign bram_we_c     = w_wr;
    assign bram_addr_c   = w_wr ? BRAM_AW'(c_IW'(r_row_cnt) * c_IW'(c_STRIDE)
                                         + c_IW'(r_col_blk) * c_IW'(c_BEATS)
                                         + c_IW'(r_beat))
                                : '0;
    assign bram_wrdata_c = w_wr ? w_buf_flat[int'(r_beat) * (c_L * W) +: BRAM_W] : '0;

    assign c_ready     = (r_state == ST_CAPTURE);
    assign blk_done    = r_blk_done;
    assign all_done    = r_all_done;
    assign busy        = (r_state != ST_IDLE);
    assign debug_state = {1'b0, r_state};

endmodule
`default_nettype wire

// File: tb/tb_gather_c.sv
`default_nettype none
// ============================================================================
// Module   : tb_gather_c
// Brief    : Randomised self-checking bench for gather_c (X=64 and X=128).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_gather_c;

    localparam int W     = 8;
    localparam int N     = 64;
    localparam int BW    = 128;
    localparam int AW    = 9;
    localparam int Y     = 64;
    localparam int BEATS = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, start, c_valid;
    logic [N-1:0][W-1:0] c_in;
    logic [BW-1:0]       rddata;
    int                  sel;

    logic a_ready, a_clk, a_en, a_we, a_blk, a_all, a_busy;
    logic b_ready, b_clk, b_en, b_we, b_blk, b_all, b_busy;
    logic [AW-1:0] a_addr, b_addr;
    logic [BW-1:0] a_wd, b_wd;
    logic [2:0]    a_dbg, b_dbg;

    gather_c #(.W(W), .N(N), .BRAM_W(BW), .BRAM_AW(AW), .DATA_C_SIZE_X(64), .DATA_C_SIZE_Y(Y)) u_a (
        .clk(clk), .rst(rst), .start(start && sel == 0), .c_in(c_in), .c_valid(c_valid && sel == 0),
        .c_ready(a_ready), .bram_clk_c(a_clk), .bram_en_c(a_en), .bram_we_c(a_we),
        .bram_addr_c(a_addr), .bram_wrdata_c(a_wd), .bram_rddata_c(rddata),
        .blk_done(a_blk), .all_done(a_all), .busy(a_busy), .debug_state(a_dbg));

    gather_c #(.W(W), .N(N), .BRAM_W(BW), .BRAM_AW(AW), .DATA_C_SIZE_X(128), .DATA_C_SIZE_Y(Y)) u_b (
        .clk(clk), .rst(rst), .start(start && sel == 1), .c_in(c_in), .c_valid(c_valid && sel == 1),
        .c_ready(b_ready), .bram_clk_c(b_clk), .bram_en_c(b_en), .bram_we_c(b_we),
        .bram_addr_c(b_addr), .bram_wrdata_c(b_wd), .bram_rddata_c(rddata),
        .blk_done(b_blk), .all_done(b_all), .busy(b_busy), .debug_state(b_dbg));

    logic          o_ready, o_clk, o_en, o_we, o_blk, o_all, o_busy;
    logic [AW-1:0] o_addr;
    logic [BW-1:0] o_wd;
    logic [2:0]    o_dbg;
    assign o_ready = sel == 0 ? a_ready : b_ready;
    assign o_clk   = sel == 0 ? a_clk   : b_clk;
    assign o_en    = sel == 0 ? a_en    : b_en;
    assign o_we    = sel == 0 ? a_we    : b_we;
    assign o_addr  = sel == 0 ? a_addr  : b_addr;
    assign o_wd    = sel == 0 ? a_wd    : b_wd;
    assign o_blk   = sel == 0 ? a_blk   : b_blk;
    assign o_all   = sel == 0 ? a_all   : b_all;
    assign o_busy  = sel == 0 ? a_busy  : b_busy;
    assign o_dbg   = sel == 0 ? a_dbg   : b_dbg;

    // Reference model: pending BRAM words plus "accepting" / "waiting" flags.
    wr_t m_q[$];
    bit  m_acc, m_wait, m_blk_p, m_all_p;
    int  m_row, m_blk, m_cb, m_stride, m_hs;

    int  n_vec, n_err;
    int  n_wr, n_blk, n_all, cyc;
    bit  hist[0:31];
    logic [AW-1:0] wr_addr[$];
    logic [BW-1:0] mem[0:(1<<AW)-1];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_acc = 0; m_wait = 0; m_blk_p = 0; m_all_p = 0;
        m_row = 0; m_blk = 0;
    endtask

    task automatic clear_obs();
        n_wr = 0; n_blk = 0; n_all = 0; cyc = 0;
        wr_addr.delete();
    endtask

    task automatic fill(input int pat);
        for (int k = 0; k < N; k++) begin
            case (pat)
                0:       c_in[k] = 8'(k);
                1:       c_in[k] = 8'(m_row);
                2:       c_in[k] = 8'(m_row) ^ 8'h80;
                default: c_in[k] = 8'($urandom);
            endcase
        end
    endtask

    task automatic step();
        bit             wr;
        wr_t            e;
        logic [AW-1:0]  exp_addr;
        logic [BW-1:0]  exp_data;
        logic [N*W-1:0] flat;
        int             exp_dbg;
        rddata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        wr = m_q.size() != 0;
        exp_addr = '0;
        exp_data = '0;
        if (wr) begin
            exp_addr = m_q[0].addr;
            exp_data = m_q[0].data;
        end
        exp_dbg = wr ? 2 : m_acc ? 1 : m_wait ? 3 : 0;
        chk("c_ready", BW'(o_ready), BW'(!wr && m_acc));
        chk("bram_en_c", BW'(o_en), BW'(wr));
        chk("bram_we_c", BW'(o_we), BW'(wr));
        chk("bram_addr_c", BW'(o_addr), BW'(exp_addr));
        chk("bram_wrdata_c", o_wd, exp_data);
        chk("blk_done", BW'(o_blk), BW'(m_blk_p));
        chk("all_done", BW'(o_all), BW'(m_all_p));
        chk("busy", BW'(o_busy), BW'(wr || m_acc || m_wait));
        chk("debug_state", BW'(o_dbg), BW'(exp_dbg));
        chk("bram_clk_c", BW'(o_clk), BW'(clk));
        if (cyc < 32) hist[cyc] = o_ready;
        cyc++;
        if (o_en) begin
            wr_addr.push_back(o_addr);
            mem[o_addr] = o_wd;
            n_wr++;
        end
        if (o_blk) n_blk++;
        if (o_all) n_all++;
        if (rst) begin
            model_reset();
        end else begin
            m_blk_p = 0;
            m_all_p = 0;
            if (wr) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    if (m_row == Y - 1) begin
                        m_blk_p = 1;
                        m_row   = 0;
                        if (m_blk == m_cb - 1) begin
                            m_all_p = 1;
                            m_blk   = 0;
                        end else begin
                            m_blk++;
                            m_wait = 1;
                        end
                    end else begin
                        m_row++;
                        m_acc = 1;
                    end
                end
            end else if (m_acc) begin
                if (c_valid) begin
                    flat = c_in;
                    for (int b = 0; b < BEATS; b++) begin
                        e.addr = AW'(m_row * m_stride + m_blk * BEATS + b);
                        e.data = flat[b*BW +: BW];
                        m_q.push_back(e);
                    end
                    m_acc = 0;
                    m_hs++;
                end
            end else if (start) begin
                if (!m_wait) begin
                    m_row = 0;
                    m_blk = 0;
                end
                m_wait = 0;
                m_acc  = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 0;
        c_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_rows(input int nrows, input int pat, input bit rnd);
        int target;
        int guard;
        bit parked;
        target = m_hs + nrows;
        guard  = 0;
        while (!(m_hs == target && m_q.size() == 0)) begin
            if (guard++ > 4000) begin
                n_vec++;
                n_err++;
                $display("FAIL run_rows timeout: %0d of %0d rows accepted", m_hs, target);
                break;
            end
            parked = m_wait || (!m_acc && m_q.size() == 0);
            if (parked && m_hs < target) start = 1;
            else if (rnd && !parked)     start = ($urandom % 3) == 0;
            else                         start = 0;
            c_valid = (m_hs < target) ? (rnd ? 1'($urandom % 2) : 1'b1) : 1'b0;
            fill(pat);
            step();
        end
        start = 0;
        c_valid = 0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_hs = 0;
        sel = 0; m_cb = 1; m_stride = 4;
        rst = 1; start = 0; c_valid = 0; c_in = '0; rddata = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset a c_ready", BW'(a_ready), '0);
        chk("reset a busy", BW'(a_busy), '0);
        chk("reset a debug_state", BW'(a_dbg), '0);
        chk("reset b bram_en_c", BW'(b_en), '0);
        rst = 0;

        // Single row, lane k = k, c_valid held from the start pulse.
        clear_obs();
        start = 1; c_valid = 1; fill(0);
        step();
        start = 0;
        for (int i = 0; i < 6; i++) step();
        idle(6);
        chk("row c_ready capture", BW'(hist[1]), BW'(1));
        for (int i = 2; i <= 5; i++) chk("row c_ready during write", BW'(hist[i]), '0);
        chk("row c_ready back", BW'(hist[6]), BW'(1));
        chk("row write count", BW'(n_wr), BW'(8));
        if (wr_addr.size() >= 4)
            for (int i = 0; i < 4; i++) chk("row address", BW'(wr_addr[i]), BW'(i));
        chk("row word0", mem[0], 128'h0f0e0d0c0b0a09080706050403020100);
        chk("row word3", mem[3], 128'h3f3e3d3c3b3a39383736353433323130);
        rst = 1; step(); rst = 0;

        // Full 64x64 matrix, lane value = row.
        clear_obs();
        run_rows(64, 1, 0);
        idle(3);
        chk("full write count", BW'(n_wr), BW'(256));
        chk("full blk_done pulses", BW'(n_blk), BW'(1));
        chk("full all_done pulses", BW'(n_all), BW'(1));
        chk("full end state", BW'(o_dbg), '0);
        chk("full word r5 b2", mem[22], {16{8'h05}});
        chk("full word r63 b3", mem[255], {16{8'h3f}});

        // Back-pressure with random data, random c_valid and stray starts.
        clear_obs();
        run_rows(64, 3, 1);
        idle(3);
        chk("bp write count", BW'(n_wr), BW'(256));
        chk("bp all_done pulses", BW'(n_all), BW'(1));

        // Reset during the second WRITE cycle of a row.
        clear_obs();
        start = 1; c_valid = 0; step();
        start = 0; c_valid = 1; fill(3); step();
        c_valid = 0; step();
        rst = 1; step();
        rst = 0;
        idle(3);
        chk("abort write count", BW'(n_wr), BW'(2));
        chk("abort idle state", BW'(o_dbg), '0);
        clear_obs();
        run_rows(1, 3, 0);
        idle(2);
        chk("restart write count", BW'(n_wr), BW'(4));
        if (wr_addr.size() > 0) chk("restart first address", BW'(wr_addr[0]), '0);
        rst = 1; step();

        // Two column blocks, X = 128.
        sel = 1; m_cb = 2; m_stride = 8;
        step();
        rst = 0;
        clear_obs();
        run_rows(64, 1, 1);
        idle(2);
        chk("blk1 state", BW'(o_dbg), BW'(3));
        chk("blk1 busy", BW'(o_busy), BW'(1));
        chk("blk1 blk_done pulses", BW'(n_blk), BW'(1));
        chk("blk1 all_done pulses", BW'(n_all), '0);
        run_rows(64, 2, 1);
        idle(3);
        chk("blk2 blk_done pulses", BW'(n_blk), BW'(2));
        chk("blk2 all_done pulses", BW'(n_all), BW'(1));
        chk("blk2 write count", BW'(n_wr), BW'(512));
        chk("blk2 end state", BW'(o_dbg), '0);
        chk("blk word r3 b1", mem[25], {16{8'h03}});
        chk("blk word r3 b5", mem[29], {16{8'h83}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gather_c.md
GATHER_C -- requirements
Module: gather_c

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- W, 8, lane width in bits.
- N, 64, systolic array lanes per result row.
- BRAM_W, 128, BRAM data width in bits.
- BRAM_AW, 9, BRAM word-address width.
- DATA_C_SIZE_X, 64, result matrix columns.
- DATA_C_SIZE_Y, 64, result matrix rows.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- start, in, 1, begin the next column block.
- c_in, in, [N-1:0][W-1:0], one result row from the array.
- c_valid, in, 1, c_in is valid.
- c_ready, out, 1, block accepts a row.
- bram_clk_c, out, 1, equals clk.
- bram_en_c, out, 1, port enable.
- bram_we_c, out, 1, write enable.
- bram_addr_c, out, BRAM_AW, word address.
- bram_wrdata_c, out, BRAM_W, write data.
- bram_rddata_c, in, BRAM_W, unused.
- blk_done, out, 1, one-cycle pulse when a column block is stored.
- all_done, out, 1, one-cycle pulse when the last block is stored.
- busy, out, 1, state is not IDLE.
- debug_state, out, 3, current state encoding.

Function
REQ-003 Derived constants:
- L = BRAM_W/W lanes per word.
- BEATS = N*W/BRAM_W words per row.
- ROWS = DATA_C_SIZE_Y.
- COL_BLKS = DATA_C_SIZE_X/N.
- STRIDE = DATA_C_SIZE_X*W/BRAM_W words per matrix row.

REQ-004 N*W SHALL be a multiple of BRAM_W; DATA_C_SIZE_X SHALL be a multiple of N; STRIDE*ROWS SHALL be at most 2^BRAM_AW. Elaboration fails otherwise.

REQ-005 State machine states: IDLE=0, CAPTURE=1, WRITE=2, WAIT=3.

REQ-006 Transitions:
- IDLE + start -> CAPTURE, with row_cnt=0, col_blk=0, beat=0.
- CAPTURE + (c_valid && c_ready) -> WRITE.
- WRITE, beat==BEATS-1, row_cnt<ROWS-1 -> CAPTURE, row_cnt+1.
- WRITE, last beat, last row, col_blk<COL_BLKS-1 -> WAIT, col_blk+1, row_cnt=0.
- WRITE, last beat, last row, last block -> IDLE.
- WAIT + start -> CAPTURE.

REQ-007 c_ready SHALL be 1 exactly in CAPTURE. A handshake SHALL copy all of c_in into an internal row buffer in that same cycle.

REQ-008 In each WRITE cycle the block SHALL assert bram_en_c=bram_we_c=1 and drive:
- bram_addr_c = row_cnt*STRIDE + col_blk*BEATS + beat.
- bram_wrdata_c = buffer lanes beat*L .. beat*L+L-1, with the lowest lane in bits [W-1:0].

REQ-009 beat SHALL increment every WRITE cycle and return to 0 on leaving WRITE.

REQ-010 Latency: handshake in cycle t puts beat b on the port in cycle t+1+b. c_ready SHALL reassert in cycle t+BEATS+1, giving one row per BEATS+1 cycles.

REQ-011 Outside WRITE, bram_en_c, bram_we_c and bram_wrdata_c SHALL be 0.

REQ-012 blk_done SHALL pulse for one cycle, in the cycle after the final beat of every column block. all_done SHALL pulse in that same cycle only for the last block.

REQ-013 start SHALL be ignored in CAPTURE and WRITE. c_valid SHALL be ignored outside CAPTURE, and c_in is not sampled.

REQ-014 Address arithmetic SHALL use at least 13-bit intermediates, truncated to BRAM_AW on output. No wrap occurs under REQ-004.

REQ-015 A start in the same cycle as the final beat SHALL be ignored; the block enters WAIT or IDLE normally.

REQ-016 bram_clk_c SHALL equal clk combinationally, and debug_state SHALL equal the state register.

Reset
REQ-017 rst is synchronous and active-high. On rst the block SHALL set state=IDLE and clear row_cnt, col_blk, beat and the row buffer. All outputs SHALL read 0 in the following cycle.

REQ-018 rst asserted mid-WRITE SHALL abort the row with no further BRAM write. The next start SHALL restart at address 0.

Structure
REQ-019 The state encoding and the derived constants of REQ-003 SHALL live in the shared package accel_pkg.

REQ-020 gather_c SHALL be a single module with no sub-module. The row buffer, counters and FSM are all inline.

Verification
REQ-021 All scenarios use N=64, W=8, BRAM_W=128, BRAM_AW=9, giving L=16 and BEATS=4.

REQ-022 Single row, X=64: start, then c_in lane k = k with c_valid held.
- Required: writes at addresses 0..3.
- Word 0 = 0x0F0E..0100; word 3 lanes 48..63.
- c_ready low for 4 cycles, then high.

REQ-023 Full matrix, X=Y=64: 64 rows, lane value = row.
- Required: 256 writes at address 4r+b, all bytes = r.
- Single blk_done and all_done pulse together; state returns to IDLE.

REQ-024 Two blocks, X=128:
- First block: rows go to addresses 8r+0..3; then blk_done without all_done, state WAIT.
- Start, second block: addresses 8r+4..7; then all_done.

REQ-025 Back-pressure: c_valid toggles randomly.
- Required: no write without a prior handshake; row order preserved.
- start pulses during WRITE are ignored.

REQ-026 Reset mid-row: rst asserted in the second WRITE cycle.
- Required: no write in the cycles after; all outputs 0.
- Next start writes address 0.
